// File: rtl/video_timing_pkg.sv
`default_nettype none
// ============================================================================
// video_timing_pkg : raster timing types, 640x480 defaults, total helpers
// Rev 1.0
// ============================================================================
package video_timing_pkg;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } timing_t;

    localparam timing_t c_h_default = '{active: 640, fp: 16, sync: 96, bp: 48};
    localparam timing_t c_v_default = '{active: 480, fp: 10, sync: 2,  bp: 33};

    function automatic int h_total(input timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

    function automatic int v_total(input timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

    // Half-open window [start, start+len); a zero length never matches.
    function automatic logic in_window(input int pos, input int start, input int len);
        return (pos >= start) && (pos < start + len);
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_timing_gen_ce_div.sv
`default_nettype none
// ============================================================================
// video_ce_div : pixel clock-enable divider, cleared while run is low
// Rev 1.0
// ============================================================================
module video_ce_div #(
    parameter int CE_DIV = 4
) (
    input  logic clk_vid,
    input  logic reset_n,
    input  logic run,
    output logic ce_pix
);

    localparam int              CW     = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam logic [CW-1:0]   c_last = CW'(CE_DIV - 1);

    logic [CW-1:0] r_ce_cnt;
    logic          r_ce;

    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            r_ce_cnt <= '0;
            r_ce     <= 1'b0;
        end else if (!run) begin
            r_ce_cnt <= '0;
            r_ce     <= 1'b0;
        end else begin
            r_ce_cnt <= (r_ce_cnt == c_last) ? '0 : r_ce_cnt + 1'b1;
            r_ce     <= (r_ce_cnt == c_last);
        end
    end

    assign ce_pix = r_ce;

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// video_timing_gen : raster counters with registered sync/blank decode
// Optional macro VIDEO_SYNC_POL_EN adds hs_neg/vs_neg sync polarity inputs.
// Rev 1.0
// ============================================================================
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int CE_DIV   = 4,
    parameter int H_ACTIVE = c_h_default.active,
    parameter int H_FP     = c_h_default.fp,
    parameter int H_SYNC   = c_h_default.sync,
    parameter int H_BP     = c_h_default.bp,
    parameter int V_ACTIVE = c_v_default.active,
    parameter int V_FP     = c_v_default.fp,
    parameter int V_SYNC   = c_v_default.sync,
    parameter int V_BP     = c_v_default.bp,
    parameter int HW       = 12,
    parameter int VW       = 11
) (
    input  logic          clk_vid,
    input  logic          reset_n,
    input  logic          run,
`ifdef VIDEO_SYNC_POL_EN
    input  logic          hs_neg,
    input  logic          vs_neg,
`endif
    output logic          ce_pix,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic          HSync,
    output logic          VSync,
    output logic          HBlank,
    output logic          VBlank,
    output logic          frame_start
);

    localparam timing_t       c_h      = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam timing_t       c_v      = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
    localparam logic [HW-1:0] c_h_last = HW'(h_total(c_h) - 1);
    localparam logic [VW-1:0] c_v_last = VW'(v_total(c_v) - 1);

    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic          r_hs, r_vs, r_hb, r_vb;
    logic [HW-1:0] w_h_next;
    logic [VW-1:0] w_v_next;

    video_ce_div #(
        .CE_DIV (CE_DIV)
    ) u_ce_div (
        .clk_vid (clk_vid),
        .reset_n (reset_n),
        .run     (run),
        .ce_pix  (ce_pix)
    );

    always_comb begin
        w_h_next = r_h;
        w_v_next = r_v;
        if (r_h == c_h_last) begin
            w_h_next = '0;
            w_v_next = (r_v == c_v_last) ? '0 : r_v + 1'b1;
        end else begin
            w_h_next = r_h + 1'b1;
        end
    end

    // Decode from the next-state counters so flags line up with hcount/vcount.
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            r_h  <= '0;
            r_v  <= '0;
            r_hs <= 1'b0;
            r_vs <= 1'b0;
            r_hb <= 1'b0;
            r_vb <= 1'b0;
        end else if (!run) begin
            r_h  <= '0;
            r_v  <= '0;
            r_hs <= 1'b0;
            r_vs <= 1'b0;
            r_hb <= 1'b0;
            r_vb <= 1'b0;
        end else if (ce_pix) begin
            r_h  <= w_h_next;
            r_v  <= w_v_next;
            r_hb <= (int'(w_h_next) >= c_h.active);
            r_vb <= (int'(w_v_next) >= c_v.active);
            r_hs <= in_window(int'(w_h_next), c_h.active + c_h.fp, c_h.sync);
            r_vs <= in_window(int'(w_v_next), c_v.active + c_v.fp, c_v.sync);
        end
    end

    assign hcount      = r_h;
    assign vcount      = r_v;
    assign HBlank      = r_hb;
    assign VBlank      = r_vb;
    assign frame_start = ce_pix & (r_h == '0) & (r_v == '0);

`ifdef VIDEO_SYNC_POL_EN
    assign HSync = r_hs ^ hs_neg;
    assign VSync = r_vs ^ vs_neg;
`else
    assign HSync = r_hs;
    assign VSync = r_vs;
`endif

endmodule
`default_nettype wire
